bsr_receiver: RTL and testbench

Receive-side counterpart of the BSG signal generator. Takes the 8-bit modulated sample stream, slices each sample against a threshold, recovers framed Gray-coded bytes, and decodes them to binary. Results go into two ping-pong data registers read over the same byte-wide register bus the BSG uses. Sits between the analog front-end sample path and the system bus, and raises an interrupt per received byte.

---
 rtl/bsr_receiver.sv | 218 +++++++++++++++++++++
 tb/tb_bsr_receiver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_receiver.sv
// bsr_receiver
// ------------------------------------------------------------------------
// Receive side of the BSG signal generator. Each 8-bit sample is sliced
// against THRESH. Framed, MSB-first Gray-coded bytes are recovered from the
// sliced stream. Each byte is converted to binary and placed into one of two
// ping-pong data registers, which are read over a byte-wide register bus.
//
// Frame (SPS samples per symbol): start(1), 8 Gray bits, [parity], stop(0).
// The idle line is 0. Every FSM timing count is in IN_VALID strobes.
//
// Optional feature: define BSR_PARITY_EN to add one even-parity symbol
// between the data bits and the stop bit. Without it, CONTROL bit 6 (PERR)
// reads 0.
//
// Ports:
//   SYS_CLK   in   1  clock
//   RST_N     in   1  asynchronous active-low reset
//   IN        in   8  modulated sample
//   IN_VALID  in   1  IN is valid this cycle
//   addr      in   8  register address (0x00 CONTROL, 0x01 DATA_0, 0x02 DATA_1)
//   Data_in   in   8  write data
//   wr_en     in   1  write strobe
//   rd_en     in   1  read strobe
//   Data_out  out  8  registered read data, valid while ready=1
//   ready     out  1  access-complete pulse, one cycle after rd_en/wr_en
//   BSR_INT   out  1  INTFLAG & INTMSK
// ------------------------------------------------------------------------
module bsr_receiver #(
    parameter int         SPS    = 4,
    parameter logic [7:0] THRESH = 8'h80
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic [7:0] IN,
    input  logic       IN_VALID,
    input  logic [7:0] addr,
    input  logic [7:0] Data_in,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] Data_out,
    output logic       ready,
    output logic       BSR_INT
);

    localparam int            CW        = $clog2(SPS) + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(SPS / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(SPS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          rx_bit, sample_pt, busy;
    logic          par_bad, perr;
    logic          rxenable, intmsk, intflag, overrun, nextbuf, ferr;
    logic [1:0]    full;
    logic [7:0]    data0, data1;
    logic          deliver, deliver_ok, ovr_set, ferr_set;
    logic          wr_ctl, rd_d0, rd_d1;
    logic [7:0]    rdata;
`ifdef BSR_PARITY_EN
    logic          perr_set;
`endif

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign rx_bit    = (IN >= THRESH);
    // cnt counts strobes down to the next mid-symbol sampling point.
    assign sample_pt = (cnt == '0);
    assign busy      = (state != IDLE);

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        deliver  = 1'b0;
        ferr_set = 1'b0;
`ifdef BSR_PARITY_EN
        perr_set = 1'b0;
`endif
        if (!rxenable) begin
            state_nx = IDLE;
        end else if (IN_VALID) begin
            case (state)
                IDLE:  if (rx_bit) state_nx = START;
                START: if (sample_pt) state_nx = rx_bit ? DATA : IDLE;
                DATA: begin
                    if (sample_pt && bit_cnt == 3'd7) begin
`ifdef BSR_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
`ifdef BSR_PARITY_EN
                PARITY: begin
                    if (sample_pt) begin
                        state_nx = STOP;
                        // Even parity: the parity bit equals the XOR of the Gray bits.
                        perr_set = (rx_bit != ^shreg);
                    end
                end
`endif
                STOP: begin
                    if (sample_pt) begin
                        state_nx = IDLE;
                        if (rx_bit) ferr_set = 1'b1;
                        else        deliver  = !par_bad;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Sample counting and bit collection advance only on valid strobes while
    // enabled. In IDLE, the detection strobe is sample 0 of the start symbol.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (IN_VALID && rxenable) begin
            if (state == IDLE) begin
                cnt     <= HALF_LOAD;
                bit_cnt <= '0;
            end else begin
                cnt <= sample_pt ? FULL_LOAD : cnt - CNT_ONE;
                if (state == DATA && sample_pt) begin
                    shreg   <= {shreg[6:0], rx_bit};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    assign wr_ctl     = wr_en && (addr == 8'h00);
    assign rd_d0      = rd_en && (addr == 8'h01);
    assign rd_d1      = rd_en && (addr == 8'h02);
    assign deliver_ok = deliver && !full[nextbuf];
    assign ovr_set    = deliver &&  full[nextbuf];

`ifdef BSR_PARITY_EN
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_bad <= 1'b0;
            perr    <= 1'b0;
        end else begin
            if (IN_VALID && state == IDLE) par_bad <= 1'b0;
            else if (perr_set)             par_bad <= 1'b1;
            perr <= (perr & ~(wr_ctl & Data_in[6])) | perr_set;
        end
    end
`else
    assign par_bad = 1'b0;
    assign perr    = 1'b0;
`endif

    always_comb begin
        rdata = 8'h00;
        case (addr)
            8'h00: rdata = {ferr, perr, nextbuf, overrun, busy, intflag, intmsk, rxenable};
            8'h01: rdata = data0;
            8'h02: rdata = data1;
            default: rdata = 8'h00;
        endcase
    end

    // Status flags use set-wins-over-W1C. Side effects of a bus access
    // land on the same edge that raises ready.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            Data_out <= 8'h00;
            ready    <= 1'b0;
            rxenable <= 1'b0;
            intmsk   <= 1'b0;
            intflag  <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
            nextbuf  <= 1'b0;
            full     <= 2'b00;
            data0    <= 8'h00;
            data1    <= 8'h00;
        end else begin
            ready <= rd_en | wr_en;
            if (rd_en) Data_out <= rdata;
            if (wr_ctl) begin
                rxenable <= Data_in[0];
                intmsk   <= Data_in[1];
            end
            intflag <= (intflag & ~(wr_ctl & Data_in[2])) | deliver_ok;
            overrun <= (overrun & ~(wr_ctl & Data_in[4])) | ovr_set;
            ferr    <= (ferr    & ~(wr_ctl & Data_in[7])) | ferr_set;
            full[0] <= (full[0] & ~rd_d0) | (deliver_ok & ~nextbuf);
            full[1] <= (full[1] & ~rd_d1) | (deliver_ok &  nextbuf);
            if (deliver_ok) begin
                if (nextbuf) data1 <= gray2bin(shreg);
                else         data0 <= gray2bin(shreg);
                nextbuf <= ~nextbuf;
            end
        end
    end

    assign BSR_INT = intflag & intmsk;

endmodule

// File: tb/tb_bsr_receiver.sv
module tb_bsr_receiver;
    localparam int SPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_s = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       ready;
    logic       bsr_int;

    always #5 clk = ~clk;

    bsr_receiver #(.SPS(SPS), .THRESH(8'h80)) dut (
        .SYS_CLK (clk),
        .RST_N   (rst_n),
        .IN      (in_s),
        .IN_VALID(in_valid),
        .addr    (addr),
        .Data_in (din),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .Data_out(dout),
        .ready   (ready),
        .BSR_INT (bsr_int)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int kv = 0;
    logic [7:0] ones_v[3]  = '{8'h80, 8'hFF, 8'hA3};
    logic [7:0] zeros_v[3] = '{8'h7F, 8'h00, 8'h41};

    // Register-level model of the receiver
    logic       m_rxen, m_msk, m_intflag, m_ovr, m_busy, m_nextbuf, m_perr, m_ferr;
    logic [7:0] m_data[2];
    logic       m_full[2];
    logic       m_ready;
    logic [7:0] m_dout;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_decode(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic m_par(input logic [7:0] g);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (g[i]) n++;
        return (n % 2) == 1;
    endfunction

    function automatic logic [7:0] m_ctrl();
        return {m_ferr, m_perr, m_nextbuf, m_ovr, m_busy, m_intflag, m_msk, m_rxen};
    endfunction

    task automatic model_reset();
        m_rxen = 0; m_msk = 0; m_intflag = 0; m_ovr = 0; m_busy = 0;
        m_nextbuf = 0; m_perr = 0; m_ferr = 0;
        m_data[0] = 8'h00; m_data[1] = 8'h00;
        m_full[0] = 0; m_full[1] = 0;
        m_ready = 0; m_dout = 8'h00;
    endtask

    task automatic model_stop(input logic [7:0] g, input logic par, input logic stop);
        logic par_fail;
        par_fail = (par != m_par(g));
`ifndef BSR_PARITY_EN
        par_fail = 1'b0;
`endif
        m_busy = 0;
        if (par_fail) m_perr = 1;
        if (stop) m_ferr = 1;
        else if (!par_fail) begin
            if (!m_full[m_nextbuf]) begin
                m_data[m_nextbuf] = m_decode(g);
                m_full[m_nextbuf] = 1;
                m_nextbuf = ~m_nextbuf;
                m_intflag = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check8("bsr_int", {7'd0, bsr_int}, {7'd0, m_intflag & m_msk});
            check8("ready", {7'd0, ready}, {7'd0, m_ready});
            check8("data_out", dout, m_dout);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_sample(input logic b);
        in_s = b ? ones_v[kv] : zeros_v[kv];
        kv = (kv + 1) % 3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_s = 8'hFF;
    endtask

    task automatic send_frame(input logic [7:0] g, input logic par, input logic stop);
        logic sym[$];
        sym.push_back(1'b1);
        for (int i = 7; i >= 0; i--) sym.push_back(g[i]);
`ifdef BSR_PARITY_EN
        sym.push_back(par);
`endif
        sym.push_back(stop);
        foreach (sym[s]) begin
            for (int i = 0; i < SPS; i++) begin
                put_sample(sym[s]);
                if (s == 0 && i == 0) m_busy = m_rxen;
                if (s == sym.size() - 1 && i == SPS / 2) model_stop(g, par, stop);
                if (i == 1) step();
            end
        end
    endtask

    task automatic send_partial(input logic [7:0] g, input int nbits);
        for (int i = 0; i < SPS; i++) begin
            put_sample(1'b1);
            if (i == 0) m_busy = m_rxen;
        end
        for (int b = 0; b < nbits; b++)
            for (int i = 0; i < SPS; i++) put_sample(g[7 - b]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put_sample(1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        m_ready = 1;
        if (a == 8'h00) begin
            m_rxen = d[0];
            m_msk  = d[1];
            if (d[2]) m_intflag = 0;
            if (d[4]) m_ovr = 0;
            if (d[7]) m_ferr = 0;
`ifdef BSR_PARITY_EN
            if (d[6]) m_perr = 0;
`endif
            if (!m_rxen) m_busy = 0;
        end
        step();
        m_ready = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] lit);
        logic [7:0] exp;
        exp = (a == 8'h00) ? m_ctrl() :
              (a == 8'h01) ? m_data[0] :
              (a == 8'h02) ? m_data[1] : 8'h00;
        addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        m_ready = 1;
        m_dout = exp;
        if (a == 8'h01) m_full[0] = 0;
        if (a == 8'h02) m_full[1] = 0;
        check8($sformatf("read_lit_%02h", a), dout, lit);
        step();
        m_ready = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        step();
        check8("rst_dout", dout, 8'h00);
        check8("rst_ready", {7'd0, ready}, 8'h00);
        check8("rst_int", {7'd0, bsr_int}, 8'h00);
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        step(); step();
        cmp_en = 1'b1;
        check8("init_dout", dout, 8'h00);
        check8("init_int", {7'd0, bsr_int}, 8'h00);
        rst_n = 1'b1;
        step();
        rd(8'h00, 8'h00);
        rd(8'h01, 8'h00);
        rd(8'h02, 8'h00);

        // Reset in the middle of a frame, then a clean frame
        wr(8'h00, 8'h03);
        rd(8'h00, 8'h03);
        send_partial(8'hF7, 3);
        do_reset();
        rd(8'h00, 8'h00);
        wr(8'h00, 8'h03);
        send_frame(8'hF7, 1'b1, 1'b0);
        rd(8'h00, 8'h27);
        check8("int_after_rx", {7'd0, bsr_int}, 8'h01);
        rd(8'h01, 8'hA5);
        wr(8'h00, 8'h07);
        rd(8'h00, 8'h23);
        check8("int_after_w1c", {7'd0, bsr_int}, 8'h00);

        // Back-to-back frames, then overrun
        do_reset();
        wr(8'h00, 8'h03);
        send_frame(8'hF7, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        rd(8'h00, 8'h07);
        send_frame(8'h55, 1'b0, 1'b0);
        rd(8'h00, 8'h17);
        rd(8'h01, 8'hA5);
        rd(8'h02, 8'h3C);

        // One-sample start glitch
        wr(8'h00, 8'h17);
        rd(8'h00, 8'h03);
        put_sample(1'b1);
        m_busy = 1;
        rd(8'h00, 8'h0B);
        put_sample(1'b0);
        put_sample(1'b0);
        m_busy = 0;
        rd(8'h00, 8'h03);

        // Framing error
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(SPS);
        rd(8'h00, 8'h83);
        check8("int_ferr", {7'd0, bsr_int}, 8'h00);
        rd(8'h01, 8'hA5);
        wr(8'h00, 8'h83);
        rd(8'h00, 8'h03);

`ifdef BSR_PARITY_EN
        send_frame(8'hF7, 1'b0, 1'b0);
        rd(8'h00, 8'h43);
        wr(8'h00, 8'h43);
        send_frame(8'hF7, 1'b1, 1'b0);
        rd(8'h00, 8'h27);
        rd(8'h01, 8'hA5);
`else
        wr(8'h00, 8'h43);
        rd(8'h00, 8'h03);
        send_frame(8'hF7, 1'b1, 1'b0);
        rd(8'h00, 8'h27);
        rd(8'h01, 8'hA5);
`endif

        // Receiver disabled mid-frame
        send_partial(8'h22, 3);
        rd(8'h00, 8'h2F);
        wr(8'h00, 8'h02);
        rd(8'h00, 8'h26);
        check8("int_disabled", {7'd0, bsr_int}, 8'h01);
        wr(8'h00, 8'h03);
        rd(8'h00, 8'h27);
        send_frame(8'h22, 1'b0, 1'b0);
        rd(8'h00, 8'h07);
        rd(8'h02, 8'h3C);

        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
